axis_frame_rx: RTL and testbench
================================

AXIS_FRAME_RX -- requirements
Module: axis_frame_rx

Interface
REQ-001 Parameter FRAME_LEN, default 1024, SHALL set the expected samples per frame (power of two, 4..65536).
REQ-002 Parameter DW, default 32, SHALL set the width of each re/im component.
REQ-003 Port clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 Ports s_tdata_re, s_tdata_im  in  DW each  SHALL carry the complex input sample.
REQ-006 Ports s_tlast  in  1, s_tvalid  in  1, s_tready  out  1  SHALL form the AXI-Stream slave handshake.
REQ-007 Ports m_re, m_im  out  DW each  SHALL carry the forwarded sample.
REQ-008 Port m_idx  out  $clog2(FRAME_LEN)  SHALL give the sample position within its frame.
REQ-009 Ports m_last  out  1, m_valid  out  1, m_ready  in  1  SHALL form the output handshake; m_last marks the final sample of the frame.
REQ-010 Ports err_early, err_late  out  1 each  SHALL be single-cycle framing-error pulses.
REQ-011 Ports frames_ok  out  32, err_cnt  out  16  SHALL be statistics counters (see Configuration).

Function
REQ-012 Input transfer SHALL occur when s_tvalid & s_tready; output transfer SHALL occur when m_valid & m_ready.
REQ-013 A 2-entry skid buffer SHALL sit between input and output; s_tready SHALL be registered and high iff the buffer holds fewer than 2 entries.
REQ-014 Latency SHALL be 1 cycle: a sample accepted at edge N into an empty buffer SHALL appear on m_* after edge N.
REQ-015 m_* SHALL hold stable while m_valid=1 and m_ready=0; order SHALL be preserved; with m_ready held at 1, throughput SHALL be 1 sample per cycle.
REQ-016 The FSM SHALL have states RUN and DROP; reset enters RUN with the index counter idx=0.
REQ-017 In RUN each accepted sample SHALL be buffered with m_idx=idx; idx then increments, or returns to 0 on frame end.
REQ-018 In RUN, tlast=1 at idx=FRAME_LEN-1 SHALL set m_last=1, wrap idx to 0 and increment frames_ok.
REQ-019 In RUN, tlast=1 at idx<FRAME_LEN-1 (early) SHALL set m_last=1, wrap idx to 0 and pulse err_early the cycle after acceptance.
REQ-020 In RUN, tlast=0 at idx=FRAME_LEN-1 (late) SHALL set m_last=1, pulse err_late the cycle after acceptance, wrap idx to 0 and enter DROP.
REQ-021 In DROP, s_tready SHALL be 1; accepted samples SHALL be discarded; the sample carrying tlast=1 SHALL also be discarded and the FSM SHALL return to RUN.
REQ-022 An error SHALL be flagged on acceptance even while the output is stalled; error pulses SHALL never be merged or lost.

Reset
REQ-023 On rst_n=0 at a clock edge: s_tready=0, m_valid=0, m_last=0, m_idx=0, m_re=m_im=0, err_early=err_late=0, frames_ok=0, err_cnt=0, buffer empty, state RUN.
REQ-024 s_tready SHALL rise the first cycle after rst_n=1; reset mid-frame SHALL discard buffered data and resume at idx=0.

Configuration
REQ-025 With macro AXIS_FRAME_RX_STAT_EN defined, frames_ok SHALL count correct frames (wrapping) and err_cnt SHALL count err_early+err_late pulses, saturating at 0xFFFF.
REQ-026 Without AXIS_FRAME_RX_STAT_EN, frames_ok and err_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification (FRAME_LEN=8, DW=32, STAT_EN defined)
REQ-027 Two back-to-back 8-sample frames, tlast on sample 7, m_ready=1 -> 16 outputs, m_idx 0..7 twice, m_last on idx 7, 1-cycle latency, frames_ok=2, no errors.
REQ-028 Frame with tlast on sample 4 -> m_last on m_idx=4, err_early pulses once, next sample emits m_idx=0, err_cnt=1.
REQ-029 10-sample frame with tlast on sample 9 -> outputs idx 0..7 with m_last at 7, err_late pulses once, samples 8-9 dropped, next frame starts at m_idx=0.
REQ-030 Continuous input, m_ready toggling 1,0,1,0 -> no loss or duplication, s_tready low only when 2 entries buffered, m_* stable while stalled.
REQ-031 rst_n low for 1 cycle after sample 3 of a frame -> all outputs at reset values; next frame emits m_idx=0 and frames_ok restarts from 0.
REQ-032 300 early-tlast frames -> err_cnt=300; with the macro undefined, frames_ok=err_cnt=0 throughout.

Source files
------------

// File: rtl/axis_frame_rx.sv
// rtl/axis_frame_rx.sv - AXI-Stream complex-sample frame receiver with framing checks and 2-entry skid buffer
// Optional statistics counters: define AXIS_FRAME_RX_STAT_EN
module axis_frame_rx #(
    parameter int FRAME_LEN = 1024,
    parameter int DW        = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DW-1:0]                s_tdata_re,
    input  logic [DW-1:0]                s_tdata_im,
    input  logic                         s_tlast,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic [DW-1:0]                m_re,
    output logic [DW-1:0]                m_im,
    output logic [$clog2(FRAME_LEN)-1:0] m_idx,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         err_early,
    output logic                         err_late,
    output logic [31:0]                  frames_ok,
    output logic [15:0]                  err_cnt
);

    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic {ST_RUN, ST_DROP} state_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [IW-1:0] idx;
        logic          last;
    } ent_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    ent_t          hd_q, hd_d;
    ent_t          tl_q, tl_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          s_tready_q, s_tready_d;
    logic          m_valid_q, m_valid_d;
    logic          err_early_q, err_early_d;
    logic          err_late_q, err_late_d;

    logic          accept;
    logic          push;
    logic          pop;
    logic          at_end;
    ent_t          in_ent;

    assign accept = s_tvalid & s_tready_q;
    assign pop    = m_valid_q & m_ready;
    assign at_end = (idx_q == IW'(FRAME_LEN - 1));

    // Framing FSM, index tracking and skid-buffer next-state logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hd_d        = hd_q;
        tl_d        = tl_q;
        cnt_d       = cnt_q;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        push        = 1'b0;
        in_ent.re   = s_tdata_re;
        in_ent.im   = s_tdata_im;
        in_ent.idx  = idx_q;
        in_ent.last = s_tlast | at_end;

        if (accept) begin
            if (state_q == ST_RUN) begin
                push  = 1'b1;
                idx_d = (s_tlast || at_end) ? '0 : idx_q + IW'(1);
                if (s_tlast && !at_end) begin
                    err_early_d = 1'b1;
                end
                if (!s_tlast && at_end) begin
                    err_late_d = 1'b1;
                    state_d    = ST_DROP;
                end
            end else if (s_tlast) begin
                state_d = ST_RUN;
            end
        end

        // Head entry drives the outputs; tail only fills when head is occupied
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    hd_d = in_ent;
                end else begin
                    tl_d = in_ent;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                hd_d  = tl_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    hd_d = in_ent;
                end else begin
                    hd_d = tl_q;
                    tl_d = in_ent;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase

        // While dropping, nothing enters the buffer, so input is always accepted
        s_tready_d = (state_d == ST_DROP) || (cnt_d != 2'd2);
        m_valid_d  = (cnt_d != 2'd0);
    end

    // Main state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            hd_q        <= '0;
            tl_q        <= '0;
            cnt_q       <= 2'd0;
            s_tready_q  <= 1'b0;
            m_valid_q   <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hd_q        <= hd_d;
            tl_q        <= tl_d;
            cnt_q       <= cnt_d;
            s_tready_q  <= s_tready_d;
            m_valid_q   <= m_valid_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    assign s_tready  = s_tready_q;
    assign m_valid   = m_valid_q;
    assign m_re      = hd_q.re;
    assign m_im      = hd_q.im;
    assign m_idx     = hd_q.idx;
    assign m_last    = hd_q.last;
    assign err_early = err_early_q;
    assign err_late  = err_late_q;

`ifdef AXIS_FRAME_RX_STAT_EN
    logic [31:0] frames_ok_q, frames_ok_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        frame_good;

    // Good frames counted at acceptance of their last sample; errors counted from the pulses
    always_comb begin
        frame_good  = accept & (state_q == ST_RUN) & s_tlast & at_end;
        frames_ok_d = frames_ok_q + {31'd0, frame_good};
        err_cnt_d   = err_cnt_q;
        if ((err_early_q || err_late_q) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_ok_q <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            frames_ok_q <= frames_ok_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frames_ok = frames_ok_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frames_ok = 32'd0;
    assign err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_axis_frame_rx.sv
// tb/tb_axis_frame_rx.sv - scoreboard bench for axis_frame_rx (FRAME_LEN=8, DW=32)
module tb_axis_frame_rx;

    localparam int FL = 8;
    localparam int DW = 32;
`ifdef AXIS_FRAME_RX_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_tdata_re;
    logic [DW-1:0] s_tdata_im;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_re;
    logic [DW-1:0] m_im;
    logic [2:0]    m_idx;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          err_early;
    logic          err_late;
    logic [31:0]   frames_ok;
    logic [15:0]   err_cnt;

    axis_frame_rx #(.FRAME_LEN(FL), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tdata_re (s_tdata_re),
        .s_tdata_im (s_tdata_im),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_idx      (m_idx),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .err_early  (err_early),
        .err_late   (err_late),
        .frames_ok  (frames_ok),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    idx;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_idx_n   = 0;
    bit m_drop    = 1'b0;
    int m_frames  = 0;
    int m_errs    = 0;
    int m_early   = 0;
    int m_late    = 0;
    int early_cyc = -1;
    int late_cyc  = -1;
    int obs_early = 0;
    int obs_late  = 0;

    bit mon_en  = 1'b0;
    bit lat_chk = 1'b0;
    bit rdy_chk = 1'b0;
    bit tg_done = 1'b0;

    logic [DW-1:0] p_re, p_im;
    logic [2:0]    p_idx;
    logic          p_last;
    bit            p_stall = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop, hold-while-stalled, error pulse timing, ready rule
    always @(negedge clk) begin
        if (mon_en) begin
            if (p_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_re", m_re, p_re);
                chk("hold_im", m_im, p_im);
                chk("hold_idx", m_idx, p_idx);
                chk("hold_last", m_last, p_last);
            end
            chk("err_early_pulse", err_early, early_cyc == cyc);
            chk("err_late_pulse", err_late, late_cyc == cyc);
            if (err_early) obs_early++;
            if (err_late) obs_late++;
            chk("valid_vs_sb", m_valid, sb.size() != 0);
            if (rdy_chk) chk("s_tready", s_tready, m_drop || (sb.size() < 2));
            if (m_valid && m_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("out_re", m_re, mon_e.re);
                chk("out_im", m_im, mon_e.im);
                chk("out_idx", m_idx, mon_e.idx);
                chk("out_last", m_last, mon_e.last);
                if (lat_chk) chk("latency", cyc, mon_e.cyc);
            end
            p_stall = m_valid && !m_ready;
            p_re    = m_re;
            p_im    = m_im;
            p_idx   = m_idx;
            p_last  = m_last;
        end else begin
            p_stall = 1'b0;
        end
    end

    task automatic model_accept(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        exp_t e;
        bit   at_end;
        if (!m_drop) begin
            at_end = (m_idx_n == FL - 1);
            e.re   = re;
            e.im   = im;
            e.idx  = m_idx_n[2:0];
            e.last = last || at_end;
            e.cyc  = cyc;
            sb.push_back(e);
            if (last && at_end) m_frames++;
            if (last && !at_end) begin
                m_early++;
                m_errs++;
                early_cyc = cyc;
            end
            if (!last && at_end) begin
                m_late++;
                m_errs++;
                late_cyc = cyc;
                m_drop   = 1'b1;
            end
            m_idx_n = (last || at_end) ? 0 : m_idx_n + 1;
        end else if (last) begin
            m_drop = 1'b0;
        end
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        bit rdy;
        int n;
        n          = 0;
        s_tvalid   = 1'b1;
        s_tdata_re = re;
        s_tdata_im = im;
        s_tlast    = last;
        do begin
            @(negedge clk);
            rdy = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("accept_timeout", 0, 1);
        else model_accept(re, im, last);
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_pos, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            send(base + DW'(i), ~(base + DW'(i)), i == last_pos);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_frames_ok"}, frames_ok, STAT ? m_frames : 0);
        chk({tag, "_err_cnt"}, err_cnt, STAT ? ((m_errs > 65535) ? 65535 : m_errs) : 0);
        chk({tag, "_early_pulses"}, obs_early, m_early);
        chk({tag, "_late_pulses"}, obs_late, m_late);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_idx"}, m_idx, 0);
        chk({tag, "_m_re"}, m_re, 0);
        chk({tag, "_m_im"}, m_im, 0);
        chk({tag, "_err_early"}, err_early, 0);
        chk({tag, "_err_late"}, err_late, 0);
        chk({tag, "_frames_ok"}, frames_ok, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata_re = '0;
        s_tdata_im = '0;
        s_tlast    = 1'b0;
        m_ready    = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("tready_rise", s_tready, 1);
        @(posedge clk);
        #1;
        mon_en  = 1'b1;
        rdy_chk = 1'b1;

        // two good back-to-back frames, 1-cycle latency
        lat_chk = 1'b1;
        send_frame(8, 7, 32'h100);
        send_frame(8, 7, 32'h200);
        lat_chk = 1'b0;
        drain();
        check_stats("good");

        // early tlast on sample 4, then a good frame
        send_frame(5, 4, 32'h300);
        send_frame(8, 7, 32'h400);
        drain();
        check_stats("early");

        // 10-sample frame: late error, samples 8-9 dropped, then a good frame
        send_frame(10, 9, 32'h500);
        send_frame(8, 7, 32'h600);
        drain();
        check_stats("late");

        // m_ready toggling with continuous input, including an error while stalled
        tg_done = 1'b0;
        fork
            begin
                send_frame(8, 7, 32'h700);
                send_frame(3, 2, 32'h900);
                send_frame(8, 7, 32'h800);
                tg_done = 1'b1;
            end
            begin
                while (!tg_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = ~m_ready;
                end
            end
        join
        m_ready = 1'b1;
        drain();
        check_stats("toggle");

        // reset for one cycle after sample 3 of a frame
        for (int i = 0; i < 4; i++) begin
            send(32'hA00 + DW'(i), ~(32'hA00 + DW'(i)), 1'b0);
        end
        @(negedge clk);
        #1;
        mon_en  = 1'b0;
        rdy_chk = 1'b0;
        rst_n   = 1'b0;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals("midreset");
        sb.delete();
        m_idx_n  = 0;
        m_drop   = 1'b0;
        m_frames = 0;
        m_errs   = 0;
        @(posedge clk);
        #1;
        mon_en  = 1'b1;
        rdy_chk = 1'b1;
        send_frame(8, 7, 32'hB00);
        drain();
        check_stats("after_reset");

        // 300 early-tlast frames
        m_errs = 0;
        for (int k = 0; k < 300; k++) begin
            send_frame(2, 1, DW'(k) << 4);
        end
        drain();
        chk("err_cnt_300", err_cnt, STAT ? 300 : 0);
        check_stats("many_early");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
